lfsr_run_ctrl: RTL and testbench

Sequencer for one LFSR characterisation run. It loads a seed into the LFSR and clears the MSB pattern counter. It then steps the LFSR until the state returns to the seed, which is one full period. After the counter pipeline settles, it latches the period length and the final pattern count. It sits between the host/UART command logic and the LFSR + MSB counter pair, and owns the counter's `max_tick` clear.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/lfsr_run_ctrl_if.sv | 35 +++
 rtl/lfsr_run_ctrl_step_counter.sv | 26 ++
 rtl/lfsr_run_ctrl.sv | 152 +++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, defaults and helpers for the LFSR characterisation
// run controller and its step counter.
package lfsr_pkg;

   localparam int DEF_LFSR_W       = 16;
   localparam int DEF_CNT_W        = 17;
   localparam int DEF_DRAIN_CYCLES = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } run_state_t;

   function automatic logic is_zero_seed(
      input logic [63:0] s
   );
      return s == 64'd0;
   endfunction

endpackage

// File: rtl/lfsr_run_ctrl_if.sv
// Bus between the run controller and the LFSR + MSB counter pair.
// master = controller side, slave = LFSR/counter side.
interface lfsr_run_ctrl_if
   import lfsr_pkg::*;
#(
   parameter int LFSR_W = DEF_LFSR_W,
   parameter int CNT_W  = DEF_CNT_W
);

   logic              lfsr_load;
   logic [LFSR_W-1:0] lfsr_seed;
   logic              lfsr_en;
   logic              max_tick;
   logic [LFSR_W-1:0] lfsr_state;
   logic [CNT_W-1:0]  count_in;

   modport master (
      output lfsr_load,
      output lfsr_seed,
      output lfsr_en,
      output max_tick,
      input  lfsr_state,
      input  count_in
   );

   modport slave (
      input  lfsr_load,
      input  lfsr_seed,
      input  lfsr_en,
      input  max_tick,
      output lfsr_state,
      output count_in
   );

endinterface

// File: rtl/lfsr_run_ctrl_step_counter.sv
// Saturating (W+1)-bit step counter with clear, enable and terminal flag.
// The terminal value 2^W is the only reachable value with the MSB set.
module step_counter
   import lfsr_pkg::*;
#(
   parameter int W = DEF_LFSR_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   output logic [W:0] q,
   output logic       term
);

   assign term = q[W];

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (en && !term) begin
         q <= q + (W+1)'(1);
      end
   end

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for one LFSR period measurement: load seed, step until the
// state returns to the seed, let the counter settle, latch the results.
module lfsr_run_ctrl
   import lfsr_pkg::*;
#(
   parameter int LFSR_W       = DEF_LFSR_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [LFSR_W-1:0] seed,
   lfsr_run_ctrl_if.master   lb,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  result,
   output logic [LFSR_W:0]   steps,
   output logic              err
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   run_state_t        state;
   run_state_t        state_n;
   logic [LFSR_W-1:0] seed_q;
   logic [LFSR_W:0]   steps_q;
   logic              term;
   logic [DW-1:0]     dcnt;
   logic              dlast;
   logic              hit;
   logic              in_run;
   logic              kill;
   logic              accept;
   logic              zero_req;
   logic              run_en;
   logic              timeout;
   logic              latch;

   step_counter #(
      .W (LFSR_W)
   ) u_steps (
      .clk   (clk),
      .reset (reset),
      .clr   (accept),
      .en    (run_en),
      .q     (steps_q),
      .term  (term)
   );

   assign in_run = (state == S_LOAD) ||
                   (state == S_RUN) ||
                   (state == S_DRAIN);
   assign kill   = abort && in_run;
   assign hit    = (steps_q != '0) &&
                   (lb.lfsr_state == seed_q);
   assign dlast  = (dcnt == DW'(DRAIN_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      zero_req = 1'b0;
      run_en   = 1'b0;
      timeout  = 1'b0;
      latch    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (is_zero_seed(64'(seed))) begin
                  zero_req = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_n = S_LOAD;
               end
            end
         end
         S_LOAD: state_n = S_RUN;
         S_RUN: begin
            // hit wins over the timeout when both land together
            if (hit) begin
               state_n = S_DRAIN;
            end else if (term) begin
               timeout = 1'b1;
               state_n = S_DRAIN;
            end else begin
               run_en = 1'b1;
            end
         end
         S_DRAIN: begin
            if (dlast) begin
               latch   = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (kill) begin
         state_n = S_IDLE;
         timeout = 1'b0;
         latch   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt <= '0;
      end else if (state == S_DRAIN) begin
         dcnt <= dcnt + DW'(1);
      end else begin
         dcnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seed_q <= '0;
         err    <= 1'b0;
         result <= '0;
         steps  <= '0;
      end else begin
         if (accept) begin
            seed_q <= seed;
            err    <= 1'b0;
         end else if (zero_req || timeout) begin
            err <= 1'b1;
         end
         if (latch) begin
            result <= lb.count_in;
            steps  <= steps_q;
         end
      end
   end

   // counter has no reset of its own, so hold it clear through reset
   assign lb.max_tick  = reset || (state == S_LOAD);
   assign lb.lfsr_load = (state == S_LOAD);
   assign lb.lfsr_seed = seed_q;
   assign lb.lfsr_en   = run_en;
   assign busy         = in_run;
   assign done         = (state == S_DONE);

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Bench for lfsr_run_ctrl: 4-bit x^4+x^3+1 LFSR with an MSB counter,
// timeline reference model and directed plus random runs.
module tb_lfsr_run_ctrl;
   import lfsr_pkg::*;

   localparam int W  = 4;
   localparam int CW = 5;
   localparam int D  = 2;

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic [W-1:0]  seed   = '0;
   logic          stuck  = 1'b0;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] result;
   logic [W:0]    steps;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   lfsr_run_ctrl_if #(.LFSR_W(W), .CNT_W(CW)) bus ();

   lfsr_run_ctrl #(
      .LFSR_W       (W),
      .CNT_W        (CW),
      .DRAIN_CYCLES (D)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
      .seed   (seed),
      .lb     (bus),
      .busy   (busy),
      .done   (done),
      .result (result),
      .steps  (steps),
      .err    (err)
   );

   always #5 clk = ~clk;

   // LFSR under test plus a two-stage MSB pattern counter
   logic [W-1:0]  lfsr_q = '0;
   logic [CW-1:0] cnt_q  = '0;
   logic [CW-1:0] cnt_o  = '0;

   always @(posedge clk) begin
      if (bus.lfsr_load) lfsr_q <= bus.lfsr_seed;
      else if (bus.lfsr_en) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      if (bus.max_tick) cnt_q <= '0;
      else if (bus.lfsr_en && bus.lfsr_state[3]) cnt_q <= cnt_q + 5'd1;
      cnt_o <= cnt_q;
   end

   assign bus.lfsr_state = stuck ? 4'h5 : lfsr_q;
   assign bus.count_in   = cnt_o;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d",
                  nm, a, e, cyc);
      end
   endtask

   // Period, timeout and MSB-count of the run a seed will produce
   task automatic walk(input logic [W-1:0] sd, input bit stk,
                       output int len, output bit to, output int cnt);
      logic [W-1:0] s;
      s = stk ? 4'h5 : sd;
      len = 0;
      cnt = 0;
      while (!(len != 0 && s == sd) && len < 16) begin
         cnt += int'(s[3]);
         s = stk ? 4'h5 : {s[2:0], s[3] ^ s[2]};
         len++;
      end
      to = !(len != 0 && s == sd);
   endtask

   // Model: a run is a timeline relative to its start cycle
   bit            m_on  = 1'b0;
   int            m_t0  = 0;
   int            m_len = 0;
   bit            m_to  = 1'b0;
   int            m_cnt = 0;
   logic          m_err = 1'b0;
   logic [CW-1:0] m_res = '0;
   logic [W:0]    m_stp = '0;
   logic [W-1:0]  m_seed = '0;
   int            mr;

   always @(posedge clk) begin
      mr = cyc - m_t0;
      if (reset) begin
         m_on = 1'b0; m_err = 1'b0; m_res = '0; m_stp = '0; m_seed = '0;
      end else if (m_on) begin
         if (abort && mr >= 1 && mr <= 2 + m_len + D) m_on = 1'b0;
         else if (mr == 2 + m_len + D) begin
            m_res = CW'(m_cnt);
            m_stp = (W+1)'(m_len);
         end else if (mr == 3 + m_len + D) m_on = 1'b0;
         if (m_on && m_to && mr == 2 + m_len) m_err = 1'b1;
      end else if (start) begin
         if (seed == '0) m_err = 1'b1;
         else begin
            m_on = 1'b1; m_t0 = cyc; m_seed = seed; m_err = 1'b0;
            walk(seed, stuck, m_len, m_to, m_cnt);
         end
      end
      cyc++;
   end

   int  cr;
   logic e_load, e_en, e_busy, e_done;

   always @(negedge clk) begin
      if (reset) begin
         chk("max_tick_in_reset", 32'(bus.max_tick), 32'd1);
      end else begin
         cr     = cyc - m_t0;
         e_load = m_on && cr == 1;
         e_en   = m_on && cr >= 2 && cr <= 1 + m_len;
         e_busy = m_on && cr >= 1 && cr <= 2 + m_len + D;
         e_done = m_on && cr == 3 + m_len + D;
         chk("lfsr_load", 32'(bus.lfsr_load), 32'(e_load));
         chk("max_tick",  32'(bus.max_tick),  32'(e_load));
         chk("lfsr_en",   32'(bus.lfsr_en),   32'(e_en));
         chk("busy",      32'(busy),          32'(e_busy));
         chk("done",      32'(done),          32'(e_done));
         chk("err",       32'(err),           32'(m_err));
         chk("result",    32'(result),        32'(m_res));
         chk("steps",     32'(steps),         32'(m_stp));
         chk("lfsr_seed", 32'(bus.lfsr_seed), 32'(m_seed));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [W-1:0] sd, output int t0);
      start = 1'b1;
      seed  = sd;
      t0    = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      int n;
      n  = 0;
      dc = -1;
      while (n < 80 && dc < 0) begin
         tick();
         n++;
         if (done) dc = cyc;
      end
      if (dc < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none required=pulse cycle=%0d", cyc);
      end
   endtask

   int t0, dc, mode, ab;
   logic [W-1:0] sd;

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // full period from seed 1
      run(4'h1, t0);
      chk("model_len", 32'(m_len), 32'd15);
      chk("model_cnt", 32'(m_cnt), 32'd8);
      wait_done(dc);
      chk("done_cycle", 32'(dc - t0), 32'd20);
      chk("steps_15", 32'(steps), 32'd15);
      chk("result_8", 32'(result), 32'd8);
      chk("err_clear", 32'(err), 32'd0);
      tick();

      // zero seed rejected
      run(4'h0, t0);
      chk("zero_err", 32'(err), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      tick();

      // abort in RUN cycle 8
      run(4'h1, t0);
      while (cyc < t0 + 8) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_steps_kept", 32'(steps), 32'd15);
      repeat (25) tick();
      run(4'h2, t0);
      wait_done(dc);
      chk("after_abort_steps", 32'(steps), 32'd15);
      tick();

      // stuck LFSR times out
      stuck = 1'b1;
      run(4'h3, t0);
      wait_done(dc);
      chk("timeout_cycle", 32'(dc - t0), 32'd21);
      chk("timeout_steps", 32'(steps), 32'd16);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_result", 32'(result), 32'd0);
      stuck = 1'b0;
      tick();

      // second start while busy is ignored
      run(4'h1, t0);
      repeat (4) tick();
      start = 1'b1;
      seed  = 4'h8;
      tick();
      start = 1'b0;
      wait_done(dc);
      chk("busy_start_cycle", 32'(dc - t0), 32'd20);
      chk("busy_start_seed", 32'(bus.lfsr_seed), 32'd1);
      chk("busy_start_err", 32'(err), 32'd0);
      tick();

      // reset in cycle 10 of a run
      run(4'h7, t0);
      while (cyc < t0 + 10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_steps", 32'(steps), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_seed", 32'(bus.lfsr_seed), 32'd0);
      run(4'h7, t0);
      wait_done(dc);
      chk("rst_rerun_steps", 32'(steps), 32'd15);
      tick();

      // random runs, aborts and stray starts
      for (int it = 0; it < 40; it++) begin
         sd = 4'($urandom_range(0, 15));
         run(sd, t0);
         if (sd == '0) begin
            tick();
         end else begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
               ab = int'($urandom_range(1, 20));
               while (cyc < t0 + ab) tick();
               abort = 1'b1;
               tick();
               abort = 1'b0;
               tick();
            end else begin
               if (mode == 1) begin
                  repeat ($urandom_range(1, 10)) tick();
                  start = 1'b1;
                  seed  = 4'($urandom);
                  tick();
                  start = 1'b0;
               end
               wait_done(dc);
               tick();
            end
         end
      end

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
